wb_line_buffer: RTL and testbench

- Write-back line buffer between the cache's eviction path and the line-granular data memory.
- Accepts dirty victim lines from the cache in one cycle and drains them to memory in FIFO order.
- Lets the cache start its allocate read without waiting for the write-back to finish.
- Forwards buffered line data to cache lookups so a refill never reads stale memory.

---
 rtl/wb_line_buffer_pkg.sv | 16 +
 rtl/wb_line_buffer_tag_match.sv | 38 +++
 rtl/wb_line_buffer.sv | 146 ++++++++++++++
 tb/tb_wb_line_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_line_buffer_pkg.sv
// Shared types for the write-back line buffer.
//   wb_state_e  : drain FSM encoding (IDLE / ISSUE / WAIT)
//   line_tag_w  : width of a line tag (byte address minus line offset bits)
package wb_line_buffer_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_ISSUE = 2'd1,
    WB_WAIT  = 2'd2
  } wb_state_e;

  function automatic int line_tag_w(input int line_size);
    return 32 - $clog2(line_size);
  endfunction

endpackage

// File: rtl/wb_line_buffer_tag_match.sv
// DEPTH-way line-tag compare with youngest-wins priority.
//   valid_i : per-entry valid mask
//   tag_i   : per-entry line tags
//   key_i   : tag to look up
//   head_i  : oldest entry; age increases walking forward from head
//   hit_o   : some masked-in entry matches
//   idx_o   : index of the youngest matching entry
module wb_tag_match
  import wb_line_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TW    = 28,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][TW-1:0] tag_i,
  input  logic [TW-1:0]            key_i,
  input  logic [PW-1:0]            head_i,
  output logic                     hit_o,
  output logic [PW-1:0]            idx_o
);

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] j;
    j     = '0;
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      j = head_i + PW'(k);
      if (valid_i[j] && tag_i[j] == key_i) begin
        hit_o = 1'b1;
        idx_o = j;
      end
    end
  end

endmodule

// File: rtl/wb_line_buffer.sv
// Write-back line buffer between cache eviction and line-granular memory.
// Victim lines are accepted in one cycle, merged into a pending entry for the
// same line when possible, drained oldest-first, and forwarded to refill
// lookups so the cache never reads stale memory.
//   clk, reset                 : clock, synchronous active-high reset
//   wb_valid/wb_addr/wb_data   : victim push; wb_ready = room available
//   lk_addr -> lk_hit/lk_data  : combinational lookup, youngest match wins
//   empty                      : nothing buffered and drain idle
//   mem_*                      : write request toward data memory
module wb_line_buffer
  import wb_line_buffer_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int DEPTH     = 4,
  localparam int DW       = LINE_SIZE * 8,
  localparam int TW       = line_tag_w(LINE_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [31:0]   wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic [31:0]   lk_addr,
  output logic          lk_hit,
  output logic [DW-1:0] lk_data,
  output logic          empty,
  output logic          mem_is_input_valid,
  output logic [TW-1:0] mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_din,
  input  logic          mem_ready
);

  localparam int OFF = $clog2(LINE_SIZE);
  localparam int PW  = $clog2(DEPTH);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][TW-1:0] tag_q, tag_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [PW:0]              count_q, count_d;
  wb_state_e                state_q, state_d;

  logic [TW-1:0]    wb_tag, lk_tag;
  logic             in_flight, push, push_new, pop, mg_hit;
  logic [PW-1:0]    mg_idx, lk_idx;
  logic [DEPTH-1:0] head_oh, mg_valid;
  logic             unused_ok;

  assign wb_tag    = wb_addr[31:OFF];
  assign lk_tag    = lk_addr[31:OFF];
  assign unused_ok = ^{wb_addr[OFF-1:0], lk_addr[OFF-1:0]};

  assign in_flight = (state_q != WB_IDLE);
  assign head_oh   = {{(DEPTH-1){1'b0}}, 1'b1} << head_q;
  // The in-flight head already has its data on the bus; never merge into it.
  assign mg_valid  = valid_q & ~(in_flight ? head_oh : '0);

  assign wb_ready  = (count_q != (PW+1)'(DEPTH));
  assign push      = wb_valid && wb_ready;
  assign push_new  = push && !mg_hit;
  assign pop       = (state_q == WB_WAIT) && mem_ready;
  assign empty     = (count_q == '0) && (state_q == WB_IDLE);

  wb_tag_match #(.DEPTH(DEPTH), .TW(TW)) u_lk_match (
    .valid_i(valid_q), .tag_i(tag_q), .key_i(lk_tag), .head_i(head_q),
    .hit_o(lk_hit), .idx_o(lk_idx)
  );

  wb_tag_match #(.DEPTH(DEPTH), .TW(TW)) u_mg_match (
    .valid_i(mg_valid), .tag_i(tag_q), .key_i(wb_tag), .head_i(head_q),
    .hit_o(mg_hit), .idx_o(mg_idx)
  );

  assign lk_data = lk_hit ? data_q[lk_idx] : '0;

  // Storage next-state. Pop only happens in WAIT, where the head is excluded
  // from merging, so push and pop never touch the same entry.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      if (mg_hit) begin
        data_d[mg_idx] = wb_data;
      end else begin
        valid_d[tail_q] = 1'b1;
        tag_d[tail_q]   = wb_tag;
        data_d[tail_q]  = wb_data;
        tail_d          = tail_q + PW'(1);
      end
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    count_d = count_q + {{PW{1'b0}}, push_new} - {{PW{1'b0}}, pop};
  end

  // Drain FSM next-state and memory request outputs.
  always_comb begin
    state_d            = state_q;
    mem_is_input_valid = 1'b0;
    mem_addr           = '0;
    mem_din            = '0;
    case (state_q)
      WB_IDLE:  if (count_q != '0) state_d = WB_ISSUE;
      WB_ISSUE: begin
        mem_is_input_valid = 1'b1;
        mem_addr           = tag_q[head_q];
        mem_din            = data_q[head_q];
        if (mem_ready) state_d = WB_WAIT;
      end
      WB_WAIT:  if (mem_ready) state_d = WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
  end

  assign mem_write = mem_is_input_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= WB_IDLE;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_wb_line_buffer.sv
module tb_wb_line_buffer;
  localparam int DP = 4;
  localparam int DW = 128;
  localparam int TW = 28;

  logic          clk = 1'b0;
  logic          reset, wb_valid, mem_ready;
  logic [31:0]   wb_addr, lk_addr;
  logic [DW-1:0] wb_data;
  logic          wb_ready, lk_hit, empty, mem_is_input_valid, mem_write;
  logic [DW-1:0] lk_data, mem_din;
  logic [TW-1:0] mem_addr;

  always #5 clk = ~clk;

  wb_line_buffer #(.LINE_SIZE(16), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data), .empty(empty),
    .mem_is_input_valid(mem_is_input_valid), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_din(mem_din), .mem_ready(mem_ready)
  );

  typedef struct {logic [TW-1:0] tag; logic [DW-1:0] data;} line_t;

  // Reference: queue of buffered lines (front = oldest) and a drain phase:
  // 0 = nothing started, 1 = request on the bus, 2 = awaiting completion.
  line_t mq[$];
  int    phase = 0;
  line_t wlog[$];   // memory writes seen on the bus

  int checks = 0, errors = 0;
  logic          last_mv, last_empty, last_rdy, last_hit;
  logic [TW-1:0] last_ma;
  logic [DW-1:0] last_md, last_lkd;

  localparam logic [DW-1:0] A5 = {16{8'hA5}};
  localparam logic [DW-1:0] D1 = {4{32'h1111_0001}};
  localparam logic [DW-1:0] D2 = {4{32'h2222_0002}};

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    logic          eh;
    logic [DW-1:0] ed, emd;
    logic [TW-1:0] ema;
    eh = 1'b0; ed = '0; ema = '0; emd = '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].tag == lk_addr[31:4]) begin eh = 1'b1; ed = mq[i].data; break; end
    if (phase == 1 && mq.size() > 0) begin ema = mq[0].tag; emd = mq[0].data; end
    chk("wb_ready",  wb_ready, mq.size() < DP);
    chk("empty",     empty, mq.size() == 0 && phase == 0);
    chk("lk_hit",    lk_hit, eh);
    chk("lk_data",   lk_data, ed);
    chk("mem_valid", mem_is_input_valid, phase == 1);
    chk("mem_write", mem_write, phase == 1);
    chk("mem_addr",  mem_addr, ema);
    chk("mem_din",   mem_din, emd);
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [31:0] a,
                            input logic [DW-1:0] d, input logic mr);
    int n;
    bit merged;
    n = mq.size();
    merged = 0;
    if (rst) begin
      mq.delete();
      phase = 0;
      return;
    end
    if (v && n < DP) begin
      for (int i = (phase != 0) ? 1 : 0; i < n; i++)
        if (mq[i].tag == a[31:4]) begin mq[i].data = d; merged = 1; end
      if (!merged) mq.push_back('{a[31:4], d});
    end
    if (phase == 2 && mr) void'(mq.pop_front());
    case (phase)
      0: if (n > 0) phase = 1;
      1: if (mr) phase = 2;
      default: if (mr) phase = 0;
    endcase
  endtask

  // One clock: drive at negedge, check #1 later, advance the model at posedge.
  task automatic cyc(input logic rst, input logic v, input logic [31:0] a,
                     input logic [DW-1:0] d, input logic [31:0] la, input logic mr);
    reset = rst; wb_valid = v; wb_addr = a; wb_data = d; lk_addr = la; mem_ready = mr;
    #1;
    compare_all();
    last_mv = mem_is_input_valid; last_empty = empty; last_rdy = wb_ready;
    last_hit = lk_hit; last_ma = mem_addr; last_md = mem_din; last_lkd = lk_data;
    if (mem_is_input_valid && mr) wlog.push_back('{mem_addr, mem_din});
    @(posedge clk);
    model_step(rst, v, a, d, mr);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic mr, input logic [31:0] la);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, '0, la, mr);
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; lk_addr = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    cyc(1'b0, 1'b0, 32'h0, '0, 32'h0, 1'b0);
    chk("rst_ready", last_rdy, 1);
    chk("rst_empty", last_empty, 1);
    chk("rst_mv", last_mv, 0);

    // Single push, request appears two cycles later
    cyc(1'b0, 1'b1, 32'h40, A5, 32'h0, 1'b1);
    idle(2, 1'b1, 32'h0);
    chk("tp1_req", last_mv, 1);
    chk("tp1_addr", last_ma, 28'h4);
    chk("tp1_din", last_md, A5);
    idle(2, 1'b1, 32'h0);
    chk("tp1_empty", last_empty, 1);

    // Fill to DEPTH, overflow ignored, drain in order
    wlog.delete();
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 32'(i) << 8, DW'(i), 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h500, DW'(5), 32'h0, 1'b0);
    chk("tp2_full_rdy", last_rdy, 0);
    idle(20, 1'b1, 32'h0);
    chk("tp2_nwr", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("tp2_order", wlog[i].tag, 28'(i + 1) << 4);
      chk("tp2_data", wlog[i].data, DW'(i + 1));
    end

    // Merge into a not-yet-in-flight entry
    wlog.delete();
    cyc(1'b0, 1'b1, 32'h80, D1, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h80, D2, 32'h0, 1'b0);
    idle(10, 1'b1, 32'h0);
    chk("tp3_nwr", wlog.size(), 1);
    if (wlog.size() > 0) chk("tp3_data", wlog[0].data, D2);

    // Same line pushed while head in flight -> two writes, lookup sees newest
    wlog.delete();
    cyc(1'b0, 1'b1, 32'h80, D1, 32'h80, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, '0, 32'h80, 1'b0);
    cyc(1'b0, 1'b1, 32'h80, D2, 32'h80, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, '0, 32'h80, 1'b0);
    chk("tp4_hit", last_hit, 1);
    chk("tp4_lkd", last_lkd, D2);
    idle(12, 1'b1, 32'h80);
    chk("tp4_nwr", wlog.size(), 2);
    if (wlog.size() > 1) begin
      chk("tp4_first", wlog[0].data, D1);
      chk("tp4_second", wlog[1].data, D2);
    end

    // Lookup with in-line offset and with a different line
    cyc(1'b0, 1'b1, 32'h80, D1, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, '0, 32'h84, 1'b0);
    chk("tp5_hit", last_hit, 1);
    chk("tp5_data", last_lkd, D1);
    cyc(1'b0, 1'b0, 32'h0, '0, 32'h90, 1'b0);
    chk("tp5_miss", last_hit, 0);
    chk("tp5_miss_data", last_lkd, 0);
    idle(8, 1'b1, 32'h0);

    // Reset while the drain is waiting for completion
    cyc(1'b0, 1'b1, 32'h100, D1, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h200, D2, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h300, A5, 32'h0, 1'b1);
    chk("tp6_in_wait", phase, 2);
    cyc(1'b1, 1'b0, 32'h0, '0, 32'h200, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, '0, 32'h200, 1'b0);
    chk("tp6_empty", last_empty, 1);
    chk("tp6_ready", last_rdy, 1);
    chk("tp6_mv", last_mv, 0);
    chk("tp6_hit", last_hit, 0);

    // Randomized traffic over a small set of lines to force merges and hits
    for (int c = 0; c < 600; c++) begin
      logic [31:0]   a, la;
      logic [DW-1:0] d;
      a  = (32'($urandom_range(0, 5)) << 4) | 32'($urandom_range(0, 15));
      la = (32'($urandom_range(0, 6)) << 4) | 32'($urandom_range(0, 15));
      d  = {$urandom, $urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), a, d, la,
          1'($urandom_range(0, 9) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
